// File: rtl/lcd_print_arbiter_if.sv
// Signals between the requesters, the print arbiter and lcd_string.
// The arbiter takes the master side; requesters plus lcd_string take the slave side.
interface lcd_print_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ*128-1:0]  req_topline;
  logic [NREQ*128-1:0]  req_bottomline;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;
  logic                 busy;
  logic                 lcd_available;
  logic                 lcd_print;
  logic [127:0]         lcd_topline;
  logic [127:0]         lcd_bottomline;

  modport master (
    input  req, req_topline, req_bottomline, lcd_available,
    output grant, done, err, busy, lcd_print, lcd_topline, lcd_bottomline
  );

  modport slave (
    output req, req_topline, req_bottomline, lcd_available,
    input  grant, done, err, busy, lcd_print, lcd_topline, lcd_bottomline
  );
endinterface

// File: rtl/lcd_print_arbiter.sv
// Round-robin arbiter sharing one lcd_string printer between NREQ requesters.
// Latches the owner's two lines and runs the print/available handshake.
module lcd_print_arbiter #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 reset,
  lcd_print_arbiter_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef logic [IW-1:0]   idx_t;
  typedef logic [IW:0]     sum_t;
  typedef logic [CW-1:0]   cnt_t;
  typedef logic [NREQ-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t       state;
  vec_t         grant;
  idx_t         owner;
  idx_t         ptr;
  cnt_t         cnt;
  logic [127:0] topline;
  logic [127:0] bottomline;

  logic         pick_valid;
  idx_t         pick_idx;
  idx_t         cand;
  sum_t         sum;
  logic [127:0] sel_top;
  logic [127:0] sel_bottom;
  idx_t         next_ptr;
  logic         timeout_hit;

  // First requesting index at or after ptr, wrapping at NREQ-1.
  // NOTE: every variable gets a default before the loop, otherwise always_comb infers a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = sum_t'(ptr) + sum_t'(k);
      if (sum >= sum_t'(NREQ)) sum = sum - sum_t'(NREQ);
      cand = idx_t'(sum);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_top    = '0;
    sel_bottom = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == idx_t'(i)) begin
        sel_top    = bus.req_topline[128*i +: 128];
        sel_bottom = bus.req_bottomline[128*i +: 128];
      end
    end
  end

  assign next_ptr    = (owner == idx_t'(NREQ - 1)) ? '0 : owner + idx_t'(1);
  assign timeout_hit = bus.lcd_available && (cnt == cnt_t'(BUSY_TIMEOUT - 1));

  // done/err coincide with the deciding cycle so the owner can drop req before the next IDLE cycle.
  assign bus.grant          = grant;
  assign bus.busy           = (state != IDLE);
  assign bus.lcd_print      = (state == ISSUE) && bus.lcd_available;
  assign bus.done           = (state == WAIT_DONE && bus.lcd_available) ? grant : '0;
  assign bus.err            = (state == WAIT_BUSY && timeout_hit) ? grant : '0;
  assign bus.lcd_topline    = topline;
  assign bus.lcd_bottomline = bottomline;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      topline    <= '0;
      bottomline <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= vec_t'(1) << pick_idx;
            owner      <= pick_idx;
            topline    <= sel_top;
            bottomline <= sel_bottom;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.lcd_available) begin
            cnt   <= '0;
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.lcd_available) begin
            state <= WAIT_DONE;
          end else if (timeout_hit) begin
            grant <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.lcd_available) begin
            grant <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_print_arbiter.sv
// Directed bench for lcd_print_arbiter: a vector table of print transactions
// plus hand sequences for late print, timeout and reset mid-print.
module tb_lcd_print_arbiter;
  localparam int NREQ         = 4;
  localparam int BUSY_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;

  lcd_print_arbiter_if #(.NREQ(NREQ)) bus ();

  lcd_print_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    int         lat;
    int         drop_after;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  int lat       = 20;
  bit stuck     = 1'b0;
  bit force_low = 1'b0;

  logic [127:0] tops[4];
  logic [127:0] bottoms[4];

  // lcd_string stand-in: available drops the cycle after print, returns lat cycles later.
  initial begin : lcd_model
    int   left;
    logic pr;
    left = 0;
    bus.lcd_available = 1'b1;
    forever begin
      @(posedge clk);
      pr = bus.lcd_print;
      #1;
      if (reset)                left = 0;
      else if (pr && !stuck)    left = lat;
      else if (left > 0)        left--;
      bus.lcd_available = !force_low && (left == 0);
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Called at a negedge in IDLE right after req was set; returns at the grant negedge.
  task automatic wait_grant(input logic [3:0] exp_g, input string nm);
    int cyc;
    int ix;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant == '0 && cyc < 10);
    ix = idx_of(exp_g);
    check({nm, " grant"}, bus.grant, exp_g);
    check({nm, " grant latency"}, cyc, 1);
    check({nm, " topline"}, bus.lcd_topline, tops[ix]);
    check({nm, " bottomline"}, bus.lcd_bottomline, bottoms[ix]);
    check({nm, " busy"}, bus.busy, 1'b1);
  endtask

  // Runs from the grant negedge to done/err, then checks the idle bubble.
  task automatic wait_finish(input logic [3:0] exp_g, input int drop_after,
                             input bit expect_err, input bit late, input string nm);
    int   prints;
    int   print_cyc;
    int   cyc;
    bit   fin;
    bit   steady;
    logic prev_av;
    prints    = 0;
    print_cyc = -1;
    cyc       = 0;
    fin       = 1'b0;
    steady    = 1'b1;
    prev_av   = bus.lcd_available;
    if (bus.lcd_print) begin
      prints++;
      print_cyc = 0;
    end
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (drop_after > 0 && cyc == drop_after) bus.req = bus.req & ~exp_g;
      if (bus.lcd_print) begin
        prints++;
        print_cyc = cyc;
      end
      if (bus.grant !== exp_g || bus.busy !== 1'b1) steady = 1'b0;
      if (bus.done != '0 || bus.err != '0) fin = 1'b1;
      else prev_av = bus.lcd_available;
    end
    check({nm, " finished in budget"}, fin, 1'b1);
    check({nm, " grant held"}, steady, 1'b1);
    check({nm, " print pulses"}, prints, 1);
    if (!late) check({nm, " print in grant cycle"}, print_cyc, 0);
    if (expect_err) begin
      check({nm, " err"}, bus.err, exp_g);
      check({nm, " no done"}, bus.done, 4'b0000);
      check({nm, " timeout cycles"}, cyc - print_cyc, BUSY_TIMEOUT);
    end else begin
      check({nm, " done"}, bus.done, exp_g);
      check({nm, " no err"}, bus.err, 4'b0000);
      check({nm, " done on available rise"}, {prev_av, bus.lcd_available}, 2'b01);
    end
    bus.req = bus.req & ~exp_g;
    @(negedge clk);
    check({nm, " bubble grant"}, bus.grant, 4'b0000);
    check({nm, " bubble busy"}, bus.busy, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[10];
    int   lowprints;

    tops[0]    = "SCORE 0042      ";
    tops[1]    = "STATUS: READY   ";
    tops[2]    = "DBG A=5A B=C3   ";
    tops[3]    = "LIVES 3 LEVEL 07";
    bottoms[0] = "HI 0099         ";
    bottoms[1] = "LINK OK  CH 04  ";
    bottoms[2] = "PC 0x1F SP 0x3C ";
    bottoms[3] = "PRESS START     ";

    // Pointer walk: 0 ->1 ->2 ->3 ->0 ->1 ->3 ->1 ->3 ->2 ->0
    vecs[0] = '{4'b0001, 4'b0001, 300, 0};
    vecs[1] = '{4'b1111, 4'b0010, 20, 0};
    vecs[2] = '{4'b1111, 4'b0100, 20, 0};
    vecs[3] = '{4'b1111, 4'b1000, 20, 0};
    vecs[4] = '{4'b1111, 4'b0001, 20, 0};
    vecs[5] = '{4'b0101, 4'b0100, 20, 0};
    vecs[6] = '{4'b0011, 4'b0001, 20, 0};
    vecs[7] = '{4'b0100, 4'b0100, 20, 2};
    vecs[8] = '{4'b0110, 4'b0010, 20, 0};
    vecs[9] = '{4'b1000, 4'b1000, 20, 0};

    reset              = 1'b1;
    bus.req            = '0;
    bus.req_topline    = {tops[3], tops[2], tops[1], tops[0]};
    bus.req_bottomline = {bottoms[3], bottoms[2], bottoms[1], bottoms[0]};
    repeat (2) @(negedge clk);
    check("reset grant", bus.grant, 4'b0000);
    check("reset done/err", {bus.done, bus.err}, 8'h00);
    check("reset busy/print", {bus.busy, bus.lcd_print}, 2'b00);
    check("reset topline", bus.lcd_topline, 128'd0);
    check("reset bottomline", bus.lcd_bottomline, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      lat     = vecs[v].lat;
      bus.req = vecs[v].req;
      wait_grant(vecs[v].exp_grant, $sformatf("vec%0d", v));
      wait_finish(vecs[v].exp_grant, vecs[v].drop_after, 1'b0, 1'b0, $sformatf("vec%0d", v));
    end

    // Late print: available held low for 50 cycles after grant.
    force_low = 1'b1;
    @(negedge clk);
    bus.req = 4'b0010;
    wait_grant(4'b0010, "late");
    lowprints = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.lcd_print) lowprints++;
      @(negedge clk);
    end
    check("late no print while unavailable", lowprints, 0);
    force_low = 1'b0;
    wait_finish(4'b0010, 0, 1'b0, 1'b1, "late");

    // Timeout: available never falls after print.
    stuck   = 1'b1;
    bus.req = 4'b0100;
    wait_grant(4'b0100, "timeout");
    wait_finish(4'b0100, 0, 1'b1, 1'b0, "timeout");
    stuck = 1'b0;

    // Next grant after timeout goes to owner+1, then reset lands in WAIT_DONE.
    bus.req = 4'b1011;
    wait_grant(4'b1000, "after timeout");
    repeat (5) @(negedge clk);
    check("pre-reset in WAIT_DONE", {bus.busy, bus.lcd_available}, 2'b10);
    reset = 1'b1;
    #1;
    check("async reset grant", bus.grant, 4'b0000);
    check("async reset busy/print", {bus.busy, bus.lcd_print}, 2'b00);
    check("async reset done/err", {bus.done, bus.err}, 8'h00);
    check("async reset topline", bus.lcd_topline, 128'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    bus.req = 4'b1010;
    wait_grant(4'b0010, "post reset");
    wait_finish(4'b0010, 0, 1'b0, 1'b0, "post reset");

    bus.req = 4'b1111;
    wait_grant(4'b0100, "final");
    wait_finish(4'b0100, 0, 1'b0, 1'b0, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_print_arbiter.md
Name: lcd_print_arbiter

Overview:
- Shares one lcd_string text printer between NREQ independent requesters, e.g. score display, status messages and debug readout.
- Round-robin arbitration selects one requester and captures its two 16-character lines.
- Runs the print/available handshake with lcd_string and pulses a per-requester done when the LCD write has fully completed.
- Sits between the game/application logic and lcd_string.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 15, max cycles to wait for lcd_available to fall after print before flagging an error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester print request, level; bit i held high until done[i].
- req_topline  in  NREQ*128  requester i's top line at bits [128*i+127:128*i], ASCII, first char in MSB byte.
- req_bottomline  in  NREQ*128  requester i's bottom line, same packing.
- grant  out  NREQ  one-hot owner of the LCD; zero when idle.
- done  out  NREQ  one-cycle pulse to the owner when its print has completed.
- err  out  NREQ  one-cycle pulse to the owner when lcd_string failed to accept print (timeout).
- busy  out  1  high whenever state is not IDLE.
- lcd_available  in  1  from lcd_string available.
- lcd_print  out  1  to lcd_string print.
- lcd_topline  out  128  to lcd_string topline; registered.
- lcd_bottomline  out  128  to lcd_string bottomline; registered.

Behaviour:
- Reset values: grant=0, done=0, err=0, busy=0, lcd_print=0, lcd_topline=0, lcd_bottomline=0, state=IDLE, rr pointer=0 (requester 0 highest priority), timeout counter=0.
- Reset mid-print: the arbiter abandons the owner without a done pulse. lcd_string shares the same reset, so both restart cleanly.

State machine:
- IDLE
  - If any req bit is set, pick the first set bit searching from index ptr upward with wrap at NREQ-1 to 0.
  - Set grant to that bit and latch its two lines into lcd_topline/lcd_bottomline, then go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE
  - Wait here until lcd_available=1.
  - In the cycle lcd_available=1, drive lcd_print=1 combinationally for that single cycle, clear the counter and go to WAIT_BUSY.
  - lcd_print is never high outside ISSUE.
- WAIT_BUSY
  - Wait for lcd_available=0, which acknowledges that lcd_string left its WAIT state, then go to WAIT_DONE.
  - Increment the counter each cycle with lcd_available=1.
  - If the counter reaches BUSY_TIMEOUT: pulse err[owner], clear grant, set ptr=owner+1 (mod NREQ) and go to IDLE.
- WAIT_DONE
  - Wait for lcd_available=1.
  - In that cycle: pulse done[owner], set ptr=owner+1 (mod NREQ), clear grant and go to IDLE.

Timing and handshake rules:
- Line data: lcd_topline/lcd_bottomline change only on the IDLE→ISSUE transition and are stable through WAIT_DONE. Requester line inputs need be valid only in the grant cycle.
- Latency: with lcd_available=1 and lcd_string idle, req rising at cycle 0 gives grant at cycle 1 and lcd_print at cycle 1 (ISSUE, available high). lcd_available falls at cycle 2, which enters WAIT_DONE.
- Deassertion: a requester deasserts req the cycle after done/err. A req still high in the IDLE cycle following done is treated as a new request, and the rr pointer already favours the others.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,…,NREQ-1,0.
- Request changes: req bits rising or falling during ISSUE/WAIT_* do not affect the current owner. A requester dropping req after grant does not abort the print.
- Pulses: done and err are mutually exclusive and at most one bit set.
- Simultaneous events: a new req arriving in the same cycle as done is evaluated in the following IDLE cycle, giving one idle bubble per print.

Test Plan:
- Single request: req=0001, req_topline[0]="SCORE 0042      ", lcd_string model (available drops 1 cycle after print, returns 300 cycles later). Expect grant=0001, one lcd_print pulse, lcd_topline matching the string, done=0001 exactly when available re-rises, then grant=0.
- Round-robin: req=1111 held, reasserted after each done. Grant order must be 0001,0010,0100,1000,0001, and each print must carry that requester's lines.
- Late print: lcd_available held 0 for 50 cycles after grant. lcd_print must stay 0 until available=1, then pulse exactly one cycle.
- Timeout: lcd_available stuck 1 after print. err[owner] must pulse after 15 cycles in WAIT_BUSY, with no done, and the next grant goes to owner+1.
- Reset mid-print: assert reset in WAIT_DONE. All outputs must go to 0 immediately (asynchronously) and ptr=0. After release, a req=1010 request must be granted to requester 1.
- Req withdrawn: drop req[2] two cycles after grant. The print must complete and done[2] must still pulse once.
